// File: rtl/quad_cmd_pkg.sv
// Shared opcodes and frame-assembly state for the host command link.
package quad_cmd_pkg;

    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;
    localparam logic [7:0] ACK       = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_CMD = 2'd1,
        GOT_HI  = 2'd2
    } frame_state_e;

endpackage

// File: rtl/uart_byte_xcvr.sv
// Bit-level 8N1 receiver and transmitter; rx and tx share only the clock and reset.
module uart_byte_xcvr
    import quad_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_byte,
    output logic       rx_rdy,
    output logic       rx_ferr,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     rx_state_q;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          rx_rdy_q, rx_ferr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_rdy_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_rdy_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end else if (rx_sync_q) begin
                        // line went back high by mid start bit: glitch, not a start
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_state_q <= RX_DATA;
                        rx_cnt_q   <= BIT_LOAD;
                        rx_bit_q   <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end else begin
                        rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
                        rx_cnt_q <= BIT_LOAD;
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end else begin
                        rx_state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            rx_rdy_q <= 1'b1;
                        end else begin
                            rx_ferr_q <= 1'b1;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte = rx_sh_q;
    assign rx_rdy  = rx_rdy_q;
    assign rx_ferr = rx_ferr_q;

    logic          tx_q, tx_busy_q;
    logic [8:0]    tx_sh_q;
    logic [3:0]    tx_nbits_q;
    logic [CW-1:0] tx_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_sh_q    <= '0;
            tx_nbits_q <= '0;
            tx_cnt_q   <= '0;
        end else if (!tx_busy_q) begin
            if (tx_start) begin
                tx_q       <= 1'b0;
                tx_sh_q    <= {1'b1, tx_byte};
                tx_nbits_q <= 4'd9;
                tx_cnt_q   <= BIT_LOAD;
                tx_busy_q  <= 1'b1;
            end
        end else if (tx_cnt_q == '0) begin
            if (tx_nbits_q == '0) begin
                tx_busy_q <= 1'b0;
            end else begin
                tx_q       <= tx_sh_q[0];
                tx_sh_q    <= {1'b0, tx_sh_q[8:1]};
                tx_nbits_q <= tx_nbits_q - 4'd1;
                tx_cnt_q   <= BIT_LOAD;
            end
        end else begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    // true during the last cycle of the stop bit
    assign tx_done = tx_busy_q && (tx_cnt_q == '0) && (tx_nbits_q == '0);

endmodule

// File: rtl/uart_cmd_if.sv
// Host command link: assembles {cmd, data_hi, data_lo} frames from UART and sends one-byte responses.
module uart_cmd_if
    import quad_cmd_pkg::*;
#(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        frm_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    logic [7:0] rx_byte;
    logic       rx_rdy, rx_ferr, tx_busy, tx_done, tx_start;

    assign tx_start = send_resp && !tx_busy;

    uart_byte_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .tx       (TX),
        .rx_byte  (rx_byte),
        .rx_rdy   (rx_rdy),
        .rx_ferr  (rx_ferr),
        .tx_byte  (resp),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    frame_state_e    state_q;
    logic [7:0]      cmd_sh_q, hi_sh_q, cmd_q;
    logic [15:0]     data_q;
    logic            cmd_rdy_q, frm_err_q, resp_sent_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            frame_done;

    assign frame_done = rx_rdy && (state_q == GOT_HI);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_sh_q    <= '0;
            hi_sh_q     <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            resp_sent_q <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            frm_err_q <= 1'b0;
            if (rx_ferr) begin
                state_q   <= IDLE;
                frm_err_q <= 1'b1;
            end else if (rx_rdy) begin
                to_cnt_q <= TO_LOAD;
                case (state_q)
                    IDLE: begin
                        cmd_sh_q  <= rx_byte;
                        cmd_rdy_q <= 1'b0;
                        state_q   <= GOT_CMD;
                    end
                    GOT_CMD: begin
                        hi_sh_q <= rx_byte;
                        state_q <= GOT_HI;
                    end
                    GOT_HI: begin
                        cmd_q     <= cmd_sh_q;
                        data_q    <= {hi_sh_q, rx_byte};
                        cmd_rdy_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (to_cnt_q == '0) begin
                    frm_err_q <= 1'b1;
                    cmd_sh_q  <= '0;
                    hi_sh_q   <= '0;
                    state_q   <= IDLE;
                end else begin
                    to_cnt_q <= to_cnt_q - 1'b1;
                end
            end

            // a completing frame outranks a simultaneous consumer clear
            if (clr_cmd_rdy && !frame_done) begin
                cmd_rdy_q <= 1'b0;
            end

            if (tx_start) begin
                resp_sent_q <= 1'b0;
            end else if (tx_done) begin
                resp_sent_q <= 1'b1;
            end
        end
    end

    assign cmd       = cmd_q;
    assign data      = data_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frm_err   = frm_err_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_if.sv
// Directed bench for uart_cmd_if, run with a short bit period and timeout to keep runtime small.
module tb_uart_cmd_if;

    localparam int B  = 16;
    localparam int H  = B / 2;
    localparam int TO = 400;
    // receiver samples 2 sync flops + 1 edge-detect cycle after the line changes
    localparam int SAMP = H + 3;

    logic        clk, rst_n, RX, TX;
    logic [7:0]  cmd, resp;
    logic [15:0] data;
    logic        cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, frm_err;

    int n_vec = 0;
    int n_err = 0;

    uart_cmd_if #(.BAUD_DIV(B), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .frm_err     (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just after the stop-bit sample edge.
    task automatic rx_bits(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        idle_clks(B);
        for (int k = 0; k < 8; k++) begin
            RX = b[k];
            idle_clks(B);
        end
        RX = stop;
        idle_clks(SAMP);
    endtask

    task automatic rx_tail();
        idle_clks(B - SAMP);
        RX = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_bits(b, 1'b1);
        rx_tail();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_clks(2);
        n_vec++; if (TX !== 1'b1)        begin n_err++; $display("FAIL reset_tx: got %b want 1", TX); end
        n_vec++; if (cmd_rdy !== 1'b0)   begin n_err++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
        n_vec++; if (cmd !== 8'h00)      begin n_err++; $display("FAIL reset_cmd: got %h want 00", cmd); end
        n_vec++; if (data !== 16'h0000)  begin n_err++; $display("FAIL reset_data: got %h want 0000", data); end
        n_vec++; if (resp_sent !== 1'b0) begin n_err++; $display("FAIL reset_resp_sent: got %b want 0", resp_sent); end
        n_vec++; if (frm_err !== 1'b0)   begin n_err++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
        rst_n = 1'b1;
        idle_clks(4);
    endtask

    task automatic test_frame_basic();
        send_byte(8'h05);
        send_byte(8'h00);
        rx_bits(8'hFF, 1'b1);
        n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL basic_rdy_early: got %b want 0", cmd_rdy); end
        @(negedge clk);
        n_vec++; if (cmd_rdy !== 1'b1)  begin n_err++; $display("FAIL basic_rdy: got %b want 1", cmd_rdy); end
        n_vec++; if (cmd !== 8'h05)     begin n_err++; $display("FAIL basic_cmd: got %h want 05", cmd); end
        n_vec++; if (data !== 16'h00FF) begin n_err++; $display("FAIL basic_data: got %h want 00ff", data); end
        rx_tail();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL basic_clr: got %b want 0", cmd_rdy); end
        n_vec++; if (cmd !== 8'h05)    begin n_err++; $display("FAIL basic_cmd_hold: got %h want 05", cmd); end
        idle_clks(B);
    endtask

    task automatic test_back_to_back();
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h00);
        n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy1: got %b want 1", cmd_rdy); end
        rx_bits(8'h03, 1'b1);
        n_vec++; if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy_pre_strobe: got %b want 1", cmd_rdy); end
        @(negedge clk);
        n_vec++; if (cmd_rdy !== 1'b0)  begin n_err++; $display("FAIL b2b_rdy_fall: got %b want 0", cmd_rdy); end
        n_vec++; if (cmd !== 8'h02)     begin n_err++; $display("FAIL b2b_cmd_hold: got %h want 02", cmd); end
        rx_tail();
        send_byte(8'hFF);
        n_vec++; if (data !== 16'h0100) begin n_err++; $display("FAIL b2b_data_hold: got %h want 0100", data); end
        // consumer clear lands on the same cycle as completion
        rx_bits(8'h80, 1'b1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        n_vec++; if (cmd_rdy !== 1'b1)  begin n_err++; $display("FAIL b2b_clr_collide: got %b want 1", cmd_rdy); end
        n_vec++; if (cmd !== 8'h03)     begin n_err++; $display("FAIL b2b_cmd2: got %h want 03", cmd); end
        n_vec++; if (data !== 16'hFF80) begin n_err++; $display("FAIL b2b_data2: got %h want ff80", data); end
        rx_tail();
        idle_clks(B);
    endtask

    task automatic test_timeout();
        int errs;
        errs = 0;
        send_byte(8'h04);
        for (int i = 0; i < TO + 10; i++) begin
            @(negedge clk);
            if (frm_err === 1'b1) errs++;
        end
        n_vec++; if (errs != 1)          begin n_err++; $display("FAIL to_pulses: got %0d want 1", errs); end
        n_vec++; if (cmd_rdy !== 1'b0)   begin n_err++; $display("FAIL to_rdy: got %b want 0", cmd_rdy); end
        n_vec++; if (cmd !== 8'h03)      begin n_err++; $display("FAIL to_cmd_kept: got %h want 03", cmd); end
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h00);
        n_vec++; if (cmd_rdy !== 1'b1)   begin n_err++; $display("FAIL to_next_rdy: got %b want 1", cmd_rdy); end
        n_vec++; if (cmd !== 8'h07)      begin n_err++; $display("FAIL to_next_cmd: got %h want 07", cmd); end
        n_vec++; if (data !== 16'h0000)  begin n_err++; $display("FAIL to_next_data: got %h want 0000", data); end
        idle_clks(B);
    endtask

    task automatic test_resp_tx();
        logic [9:0] exp_bits;
        int lows;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        resp = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        n_vec++; if (resp_sent !== 1'b0) begin n_err++; $display("FAIL tx_sent_clr: got %b want 0", resp_sent); end
        idle_clks(H);
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (TX !== exp_bits[k]) begin n_err++; $display("FAIL tx_bit%0d: got %b want %b", k, TX, exp_bits[k]); end
            if (k == 4) begin
                resp = 8'h00;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
                idle_clks(B - 1);
            end else if (k < 9) begin
                idle_clks(B);
            end
        end
        idle_clks(H - 1);
        n_vec++; if (resp_sent !== 1'b0) begin n_err++; $display("FAIL tx_sent_early: got %b want 0", resp_sent); end
        @(negedge clk);
        n_vec++; if (resp_sent !== 1'b1) begin n_err++; $display("FAIL tx_sent: got %b want 1", resp_sent); end
        lows = 0;
        for (int i = 0; i < 3 * B; i++) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        n_vec++; if (lows != 0)          begin n_err++; $display("FAIL tx_no_extra: got %0d low cycles want 0", lows); end
        n_vec++; if (resp_sent !== 1'b1) begin n_err++; $display("FAIL tx_sent_hold: got %b want 1", resp_sent); end
    endtask

    task automatic test_stop_err_and_reset();
        int errs;
        send_byte(8'h06);
        rx_bits(8'h55, 1'b0);
        errs = (frm_err === 1'b1) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frm_err === 1'b1) errs++;
        end
        n_vec++; if (errs != 1) begin n_err++; $display("FAIL stop_err_pulses: got %0d want 1", errs); end
        RX = 1'b1;
        idle_clks(2 * B);
        send_byte(8'h08);
        send_byte(8'h12);
        send_byte(8'h34);
        n_vec++; if (cmd_rdy !== 1'b1)  begin n_err++; $display("FAIL stop_next_rdy: got %b want 1", cmd_rdy); end
        n_vec++; if (cmd !== 8'h08)     begin n_err++; $display("FAIL stop_next_cmd: got %h want 08", cmd); end
        n_vec++; if (data !== 16'h1234) begin n_err++; $display("FAIL stop_next_data: got %h want 1234", data); end

        // short low glitch must not start a byte
        idle_clks(B);
        RX = 1'b0;
        idle_clks(3);
        RX = 1'b1;
        idle_clks(2 * B);
        send_byte(8'h06);
        send_byte(8'h00);
        send_byte(8'h01);
        n_vec++; if (cmd !== 8'h06 || data !== 16'h0001) begin
            n_err++; $display("FAIL glitch_frame: got %h/%h want 06/0001", cmd, data);
        end

        // reset while the line is high inside byte 2 (data F0, bit 4 = 1)
        idle_clks(B);
        send_byte(8'h05);
        RX = 1'b0;
        idle_clks(B);
        for (int k = 0; k < 4; k++) begin
            RX = 1'b0;
            idle_clks(B);
        end
        RX = 1'b1;
        idle_clks(H);
        rst_n = 1'b0;
        idle_clks(2);
        rst_n = 1'b1;
        n_vec++; if (cmd_rdy !== 1'b0 || cmd !== 8'h00 || data !== 16'h0000) begin
            n_err++; $display("FAIL rst_mid: got rdy=%b %h/%h want 0 00/0000", cmd_rdy, cmd, data);
        end
        idle_clks(12 * B);
        n_vec++; if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: got %b want 0", cmd_rdy); end
        send_byte(8'h03);
        send_byte(8'hAB);
        send_byte(8'hCD);
        n_vec++; if (cmd_rdy !== 1'b1)  begin n_err++; $display("FAIL rst_next_rdy: got %b want 1", cmd_rdy); end
        n_vec++; if (cmd !== 8'h03)     begin n_err++; $display("FAIL rst_next_cmd: got %h want 03", cmd); end
        n_vec++; if (data !== 16'hABCD) begin n_err++; $display("FAIL rst_next_data: got %h want abcd", data); end
    endtask

    initial begin
        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp        = 8'h00;
        send_resp   = 1'b0;
        @(negedge clk);
        test_reset();
        test_frame_basic();
        test_back_to_back();
        test_timeout();
        test_resp_tx();
        test_stop_err_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
